// File: rtl/keycode_in_fifo_pkg.sv
// Shared register map and bit positions for the keycode input FIFO port.
package keycode_in_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_CONTROL  = 2'd3;

  localparam int EMPTY     = 0;
  localparam int FULL      = 1;
  localparam int OVF       = 2;
  localparam int COUNT_LSB = 8;

  localparam int NE = 0;
  localparam int OV = 1;
endpackage

// File: rtl/keycode_in_fifo_if.sv
// Avalon-MM slave bus for the keycode input port.
interface keycode_in_fifo_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, read_n, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, read_n, write_n, writedata,
                  output readdata);
endinterface

// File: rtl/keycode_sync_fifo.sv
// Synchronous FIFO with combinational head; flush beats push/pop, pop on empty ignored.
module keycode_sync_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push, w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign dout  = r_mem[r_rptr];
  assign count = r_count;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign w_do_push = push & ~flush & (~full | (pop & ~empty));
  assign w_do_pop  = pop  & ~flush & ~empty;

  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end
endmodule

// File: rtl/keycode_in_fifo.sv
// Avalon-MM keycode input port: fabric pushes into a FIFO, CPU pops via DATA,
// with sticky overflow, interrupt mask and flush control.
module keycode_in_fifo
  import keycode_in_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  keycode_in_fifo_if.slave  avs,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              irq
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              w_rd, w_wr, w_pop, w_flush, w_ovf_clr, w_ovf_set;
  logic              w_push_ok, w_pop_ok, w_ovf_nxt, w_irq_nxt;
  logic [DATA_W-1:0] w_dout;
  logic [CW-1:0]     w_count, w_cnt_nxt;
  logic              w_empty, w_full;
  logic [1:0]        w_mask_nxt;
  logic [31:0]       w_rdata;
  logic              r_ovf;
  logic [1:0]        r_mask;

  assign w_rd      = avs.chipselect & ~avs.read_n;
  assign w_wr      = avs.chipselect & ~avs.write_n;
  assign w_pop     = w_rd & (avs.address == ADDR_DATA);
  assign w_flush   = w_wr & (avs.address == ADDR_CONTROL) & avs.writedata[0];
  assign w_ovf_clr = w_wr & (avs.address == ADDR_STATUS) & avs.writedata[OVF];
  assign w_ovf_set = in_valid & w_full & ~w_pop & ~w_flush;

  keycode_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (in_valid),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (in_data),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  // Mirror the FIFO's next occupancy so irq can be registered off next-state values.
  assign w_pop_ok   = w_pop & ~w_empty & ~w_flush;
  assign w_push_ok  = in_valid & ~w_flush & (~w_full | w_pop_ok);
  assign w_cnt_nxt  = w_flush ? '0 : (w_count + CW'(w_push_ok) - CW'(w_pop_ok));
  assign w_ovf_nxt  = w_ovf_set | (r_ovf & ~w_ovf_clr);
  assign w_mask_nxt = (w_wr && avs.address == ADDR_IRQ_MASK) ? avs.writedata[1:0] : r_mask;
  assign w_irq_nxt  = (w_mask_nxt[NE] & (w_cnt_nxt != '0)) | (w_mask_nxt[OV] & w_ovf_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_mask <= 2'b00;
      irq    <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_nxt;
      r_mask <= w_mask_nxt;
      irq    <= w_irq_nxt;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (avs.address)
        ADDR_DATA:     if (!w_empty) w_rdata = 32'(w_dout);
        ADDR_STATUS: begin
          w_rdata[COUNT_LSB +: 8] = 8'(w_count);
          w_rdata[OVF]            = r_ovf;
          w_rdata[FULL]           = w_full;
          w_rdata[EMPTY]          = w_empty;
        end
        ADDR_IRQ_MASK: w_rdata[1:0] = r_mask;
        default:       w_rdata = '0;
      endcase
    end
  end

  assign avs.readdata = w_rdata;
endmodule

// File: tb/tb_keycode_in_fifo.sv
// Directed table-driven bench for keycode_in_fifo (DEPTH=8, DATA_W=8).
module tb_keycode_in_fifo;
  import keycode_in_pkg::*;

  typedef enum logic [2:0] {IDLE, RD, WR, PUSH, PUSH_RD, PUSH_WR, RD_NOCS} op_e;

  typedef struct {
    op_e         op;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  din;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_irq;
    logic        exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       irq;
  int         nchk = 0;
  int         nerr = 0;
  vec_t       vq[$];

  keycode_in_fifo_if bus();

  keycode_in_fifo #(.DEPTH(8), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus),
    .in_data  (in_data),
    .in_valid (in_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(op_e op, logic [1:0] addr, logic [31:0] wd, logic [7:0] din,
                              bit chk_rd, logic [31:0] exp_rd, bit chk_irq, logic exp_irq);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.din = din;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_irq = chk_irq; v.exp_irq = exp_irq;
    vq.push_back(v);
  endfunction

  function automatic void rd(logic [1:0] a, logic [31:0] e);
    add(RD, a, 0, 0, 1, e, 0, 0);
  endfunction
  function automatic void wr(logic [1:0] a, logic [31:0] d);
    add(WR, a, d, 0, 0, 0, 0, 0);
  endfunction
  function automatic void push(logic [7:0] d);
    add(PUSH, 0, 0, d, 0, 0, 0, 0);
  endfunction
  function automatic void idle_irq(logic e);
    add(IDLE, 0, 0, 0, 0, 0, 1, e);
  endfunction

  task automatic drive_idle();
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = '0; bus.writedata = '0;
    in_valid = 1'b0; in_data = '0;
  endtask

  // Inputs set on the falling edge; readdata/irq sampled before the rising edge commits.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.chipselect = (v.op inside {RD, WR, PUSH_RD, PUSH_WR});
    bus.read_n     = !(v.op inside {RD, PUSH_RD, RD_NOCS});
    bus.write_n    = !(v.op inside {WR, PUSH_WR});
    bus.address    = v.addr;
    bus.writedata  = v.wd;
    in_valid       = (v.op inside {PUSH, PUSH_RD, PUSH_WR});
    in_data        = v.din;
    #1;
    if (v.chk_rd)  check($sformatf("vec%0d readdata", idx), bus.readdata, v.exp_rd);
    if (v.chk_irq) check($sformatf("vec%0d irq", idx), {31'b0, irq}, {31'b0, v.exp_irq});
    @(posedge clk);
    #1 drive_idle();
  endtask

  initial begin
    vec_t v;
    drive_idle();

    // Basic three-byte ordering
    push(8'h1C); push(8'h32); push(8'h23);
    rd(ADDR_STATUS, 32'h0000_0300);
    rd(ADDR_DATA, 32'h1C); rd(ADDR_DATA, 32'h32); rd(ADDR_DATA, 32'h23);
    rd(ADDR_STATUS, 32'h0000_0001);
    rd(ADDR_DATA, 32'h0);
    add(RD_NOCS, ADDR_STATUS, 0, 0, 1, 32'h0, 0, 0);

    // Overflow on the ninth push, drain, clear
    for (int i = 1; i <= 9; i++) push(8'(i));
    rd(ADDR_STATUS, 32'h0000_0806);
    for (int i = 1; i <= 8; i++) rd(ADDR_DATA, 32'(i));
    rd(ADDR_STATUS, 32'h0000_0005);
    wr(ADDR_STATUS, 32'h4);
    rd(ADDR_STATUS, 32'h0000_0001);

    // Not-empty interrupt
    wr(ADDR_IRQ_MASK, 32'h1);
    rd(ADDR_IRQ_MASK, 32'h1);
    add(PUSH, 0, 0, 8'h44, 0, 0, 1, 1'b0);
    add(RD, ADDR_DATA, 0, 0, 1, 32'h44, 1, 1'b1);
    idle_irq(1'b0);

    // Full FIFO with concurrent push and pop
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    add(PUSH_RD, ADDR_DATA, 0, 8'h55, 1, 32'hA0, 0, 0);
    rd(ADDR_STATUS, 32'h0000_0802);
    for (int i = 1; i < 8; i++) rd(ADDR_DATA, 32'hA0 + 32'(i));
    rd(ADDR_DATA, 32'h55);
    rd(ADDR_STATUS, 32'h0000_0001);
    idle_irq(1'b0);

    // Overflow interrupt, clear, and set-beats-clear
    wr(ADDR_IRQ_MASK, 32'h2);
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    add(PUSH, 0, 0, 8'hBF, 0, 0, 1, 1'b0);
    idle_irq(1'b1);
    add(WR, ADDR_STATUS, 32'h4, 0, 0, 0, 1, 1'b1);
    idle_irq(1'b0);
    add(PUSH_WR, ADDR_STATUS, 32'h4, 8'hCC, 0, 0, 0, 0);
    add(RD, ADDR_STATUS, 0, 0, 1, 32'h0000_0806, 1, 1'b1);
    wr(ADDR_IRQ_MASK, 32'h0);
    wr(ADDR_CONTROL, 32'h1);
    rd(ADDR_STATUS, 32'h0000_0005);
    wr(ADDR_STATUS, 32'h4);

    // Flush concurrent with push
    push(8'h11); push(8'h22);
    add(PUSH_WR, ADDR_CONTROL, 32'h1, 8'h77, 0, 0, 0, 0);
    rd(ADDR_STATUS, 32'h0000_0001);
    rd(ADDR_DATA, 32'h0);
    rd(ADDR_CONTROL, 32'h0);

    // Reset state
    #1;
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset readdata idle", bus.readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v = '{op: RD, addr: ADDR_STATUS, wd: 0, din: 0, chk_rd: 1, exp_rd: 32'h1, chk_irq: 1, exp_irq: 0};
    apply(v, -1);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Asynchronous reset mid-operation
    push(8'h5A); // queued only for uniform helpers; applied explicitly below
    v = '{op: WR, addr: ADDR_IRQ_MASK, wd: 32'h1, din: 0, chk_rd: 0, exp_rd: 0, chk_irq: 0, exp_irq: 0};
    apply(v, 100);
    v = '{op: PUSH, addr: 0, wd: 0, din: 8'h5A, chk_rd: 0, exp_rd: 0, chk_irq: 0, exp_irq: 0};
    apply(v, 101);
    apply(v, 102);
    @(negedge clk);
    #1 check("pre-reset irq", {31'b0, irq}, 32'h1);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = ADDR_STATUS;
    #1 check("pre-reset status", bus.readdata, 32'h0000_0200);
    reset = 1'b1;
    #1;
    check("async reset irq", {31'b0, irq}, 32'h0);
    check("async reset status", bus.readdata, 32'h0000_0001);
    bus.address = ADDR_IRQ_MASK;
    #1 check("async reset mask", bus.readdata, 32'h0);
    bus.address = ADDR_DATA;
    #1 check("async reset data", bus.readdata, 32'h0);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
